// File: rtl/memctrl_fifo_if.sv
// CPU data-bus bundle between avrcpu and memctrl_fifo.
// The master drives address/strobe/write data; the slave returns read data.
interface memctrl_fifo_if;
    logic [15:0] address;
    logic        wren;
    logic [7:0]  data_o;
    logic [7:0]  data_i;

    modport master (output address, output wren, output data_o, input data_i);
    modport slave  (input address, input wren, input data_o, output data_i);
endinterface

// File: rtl/memctrl_fifo.sv
// Memory controller: decodes CPU data addresses into SRAM, a banked video window and I/O
// registers, and buffers PS/2 scancodes in a keyboard FIFO with a sticky overflow flag.
module memctrl_fifo #(
    parameter int          KBD_DEPTH = 16,
    parameter int          BANK_W    = 5,
    parameter logic [3:0]  WIN_HI    = 4'hF,
    parameter logic [15:0] IO_BASE   = 16'h0020
) (
    input  logic                clock,
    input  logic                reset,
    memctrl_fifo_if.slave       cpu,
    input  logic [7:0]          data_o_sram,
    input  logic [7:0]          data_o_text,
    input  logic [7:0]          data_o_grph,
    output logic                data_w_sram,
    output logic                data_w_text,
    output logic                data_w_grph,
    output logic [BANK_W+11:0]  win_addr,
    output logic [7:0]          bank,
    output logic [7:0]          videomode,
    output logic [7:0]          cursor_x,
    output logic [7:0]          cursor_y,
    input  logic [7:0]          ps2_data,
    input  logic                ps2_hit,
    output logic                kbd_irq
);
    localparam int PTR_W = $clog2(KBD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OFF_BANK = 6'd0;
    localparam logic [5:0] OFF_VMOD = 6'd1;
    localparam logic [5:0] OFF_CURX = 6'd2;
    localparam logic [5:0] OFF_CURY = 6'd3;
    localparam logic [5:0] OFF_KDAT = 6'd4;
    localparam logic [5:0] OFF_KSTA = 6'd5;

    // STAT only has room for a 4-bit count, so deeper fills read as 15.
    function automatic logic [3:0] sat_count(input logic [8:0] cnt);
        sat_count = (cnt > 9'd15) ? 4'hF : cnt[3:0];
    endfunction

    logic [7:0]       r_bank;
    logic [7:0]       r_videomode;
    logic [7:0]       r_cursor_x;
    logic [7:0]       r_cursor_y;
    logic             r_ovf;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_mem [KBD_DEPTH];

    logic [16:0] w_addr_ext;
    logic [16:0] w_io_lo;
    logic        w_is_io;
    logic        w_is_win;
    logic        w_is_sram;
    logic [5:0]  w_io_off;
    logic        w_io_wr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop_req;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic [8:0]  w_cnt_ext;
    logic [7:0]  w_head;
    logic [7:0]  w_stat;
    logic [7:0]  w_rdata;

    // IO range compared in 17 bits so IO_BASE near the top of memory cannot wrap.
    assign w_addr_ext = {1'b0, cpu.address};
    assign w_io_lo    = {1'b0, IO_BASE};
    assign w_is_io    = (w_addr_ext >= w_io_lo) && (w_addr_ext < (w_io_lo + 17'h00040));
    assign w_is_win   = ~w_is_io && (cpu.address[15:12] == WIN_HI);
    assign w_is_sram  = ~w_is_io && ~w_is_win;
    assign w_io_off   = cpu.address[5:0] - IO_BASE[5:0];
    assign w_io_wr    = cpu.wren & w_is_io;

    assign data_w_sram = cpu.wren & w_is_sram;
    assign data_w_text = cpu.wren & w_is_win & ~r_bank[7];
    assign data_w_grph = cpu.wren & w_is_win &  r_bank[7];
    assign win_addr    = {r_bank[BANK_W-1:0], cpu.address[11:0]};

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(KBD_DEPTH));
    assign w_pop_req = w_io_wr && (w_io_off == OFF_KDAT);
    assign w_pop     = w_pop_req & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push    = ps2_hit & (~w_full | w_pop);
    assign w_ovf_set = ps2_hit & w_full & ~w_pop;
    assign w_ovf_clr = w_io_wr && (w_io_off == OFF_KSTA) && cpu.data_o[2];

    assign w_cnt_ext = 9'(r_count);
    assign w_head    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign w_stat    = {sat_count(w_cnt_ext), 1'b0, r_ovf, w_full, ~w_empty};

    // Read-data mux: zero-latency path back to the CPU.
    always_comb begin
        w_rdata = 8'h00;
        if (w_is_io) begin
            case (w_io_off)
                OFF_BANK: w_rdata = r_bank;
                OFF_VMOD: w_rdata = r_videomode;
                OFF_CURX: w_rdata = r_cursor_x;
                OFF_CURY: w_rdata = r_cursor_y;
                OFF_KDAT: w_rdata = w_head;
                OFF_KSTA: w_rdata = w_stat;
                default:  w_rdata = 8'h00;
            endcase
        end else if (w_is_win) begin
            w_rdata = r_bank[7] ? data_o_grph : data_o_text;
        end else begin
            w_rdata = data_o_sram;
        end
    end

    assign cpu.data_i = w_rdata;

    // Video/cursor register file.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank      <= 8'h00;
            r_videomode <= 8'h00;
            r_cursor_x  <= 8'h00;
            r_cursor_y  <= 8'h00;
        end else if (w_io_wr) begin
            case (w_io_off)
                OFF_BANK: r_bank      <= cpu.data_o;
                OFF_VMOD: r_videomode <= cpu.data_o;
                OFF_CURX: r_cursor_x  <= cpu.data_o;
                OFF_CURY: r_cursor_y  <= cpu.data_o;
                default:  ;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
            else                r_ovf <= r_ovf;
        end
    end

    // Scancode storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= ps2_data;
    end

    assign bank      = r_bank;
    assign videomode = r_videomode;
    assign cursor_x  = r_cursor_x;
    assign cursor_y  = r_cursor_y;
    assign kbd_irq   = ~w_empty;
endmodule

// File: tb/tb_memctrl_fifo.sv
// Directed bench for memctrl_fifo: address decode, register file, keyboard FIFO and reset.
module tb_memctrl_fifo;
    localparam logic [15:0] IO_BASE = 16'h0020;

    logic        clock;
    logic        reset;
    logic [7:0]  data_o_sram, data_o_text, data_o_grph;
    logic        data_w_sram, data_w_text, data_w_grph;
    logic [16:0] win_addr;
    logic [7:0]  bank, videomode, cursor_x, cursor_y;
    logic [7:0]  ps2_data;
    logic        ps2_hit;
    logic        kbd_irq;
    int          n_pass;
    int          n_total;
    logic [7:0]  rd;

    memctrl_fifo_if bus ();

    memctrl_fifo #(.KBD_DEPTH(16), .BANK_W(5), .WIN_HI(4'hF), .IO_BASE(IO_BASE)) dut (
        .clock(clock), .reset(reset), .cpu(bus),
        .data_o_sram(data_o_sram), .data_o_text(data_o_text), .data_o_grph(data_o_grph),
        .data_w_sram(data_w_sram), .data_w_text(data_w_text), .data_w_grph(data_w_grph),
        .win_addr(win_addr), .bank(bank), .videomode(videomode),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .ps2_data(ps2_data), .ps2_hit(ps2_hit), .kbd_irq(kbd_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic io_write(input logic [5:0] off, input logic [7:0] val);
        bus.address = IO_BASE + {10'd0, off};
        bus.data_o  = val;
        bus.wren    = 1'b1;
        cyc();
        bus.wren    = 1'b0;
    endtask

    task automatic io_read(input logic [5:0] off, output logic [7:0] val);
        bus.address = IO_BASE + {10'd0, off};
        bus.wren    = 1'b0;
        #1;
        val = bus.data_i;
    endtask

    task automatic push(input logic [7:0] b);
        ps2_data = b;
        ps2_hit  = 1'b1;
        cyc();
        ps2_hit  = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; ps2_hit = 1'b0; ps2_data = 8'h00;
        bus.address = 16'h0000; bus.wren = 1'b0; bus.data_o = 8'h00;
        data_o_sram = 8'hA5; data_o_text = 8'h3C; data_o_grph = 8'hC3;
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        check("rst_bank", bank, 8'h00);
        check("rst_irq", kbd_irq, 1'b0);
        io_read(6'd5, rd); check("rst_stat", rd, 8'h00);

        // 1: graphics bank write
        io_write(6'd0, 8'h81);
        check("bank_81", bank, 8'h81);
        bus.address = 16'hF123; bus.data_o = 8'h5A; bus.wren = 1'b1; #1;
        check("t1_grph", data_w_grph, 1'b1);
        check("t1_text", data_w_text, 1'b0);
        check("t1_sram", data_w_sram, 1'b0);
        check("t1_win", win_addr, 17'h01123);
        cyc(); bus.wren = 1'b0; #1;
        check("t1_rd_grph", bus.data_i, 8'hC3);

        // 2: text window, SRAM, unmapped IO, range boundaries
        io_write(6'd0, 8'h00);
        bus.address = 16'hF010; bus.wren = 1'b1; #1;
        check("t2_text", data_w_text, 1'b1);
        check("t2_grph", data_w_grph, 1'b0);
        cyc(); bus.wren = 1'b0; #1;
        check("t2_rd_text", bus.data_i, 8'h3C);
        bus.address = 16'h1234; bus.wren = 1'b1; #1;
        check("t2_sram_we", data_w_sram, 1'b1);
        check("t2_rd_sram", bus.data_i, 8'hA5);
        cyc();
        bus.address = 16'h0030; bus.wren = 1'b1; #1;
        check("t2_io_we", {data_w_sram, data_w_text, data_w_grph}, 3'b000);
        cyc(); bus.wren = 1'b0; #1;
        check("t2_unmapped", bus.data_i, 8'h00);
        bus.address = 16'h001F; #1; check("t2_below_io", bus.data_i, 8'hA5);
        bus.address = 16'h005F; #1; check("t2_io_top", bus.data_i, 8'h00);
        bus.address = 16'h0060; #1; check("t2_above_io", bus.data_i, 8'hA5);
        io_write(6'd1, 8'h12); io_write(6'd2, 8'h34); io_write(6'd3, 8'h56);
        check("t2_vmode", videomode, 8'h12);
        check("t2_curx", cursor_x, 8'h34);
        check("t2_cury", cursor_y, 8'h56);
        io_read(6'd3, rd); check("t2_rd_cury", rd, 8'h56);

        // 3: three scancodes through the FIFO
        push(8'h1C); push(8'h32); push(8'h21);
        check("t3_irq", kbd_irq, 1'b1);
        io_read(6'd5, rd); check("t3_stat", rd, 8'h31);
        io_read(6'd4, rd); check("t3_d0", rd, 8'h1C);
        io_read(6'd4, rd); check("t3_d0_again", rd, 8'h1C);
        io_write(6'd4, 8'h00); io_read(6'd4, rd); check("t3_d1", rd, 8'h32);
        io_write(6'd4, 8'h00); io_read(6'd4, rd); check("t3_d2", rd, 8'h21);
        io_write(6'd4, 8'h00);
        io_read(6'd5, rd); check("t3_stat_empty", rd, 8'h00);
        check("t3_irq_low", kbd_irq, 1'b0);

        // 4: overflow; STAT = {1111,0,ovf,full,~empty}
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        io_read(6'd5, rd); check("t4_stat_ovf", rd, 8'hF7);
        io_read(6'd4, rd); check("t4_head", rd, 8'h40);
        io_write(6'd5, 8'h04);
        io_read(6'd5, rd); check("t4_ovf_clr", rd, 8'hF3);

        // 5: push+pop while full, pops down to the new tail, empty pops
        bus.address = IO_BASE + 16'd4; bus.wren = 1'b1; ps2_data = 8'h99; ps2_hit = 1'b1;
        cyc(); bus.wren = 1'b0; ps2_hit = 1'b0;
        io_read(6'd5, rd); check("t5_full_pp", rd, 8'hF3);
        io_read(6'd4, rd); check("t5_head", rd, 8'h41);
        for (int i = 0; i < 15; i++) io_write(6'd4, 8'h00);
        io_read(6'd4, rd); check("t5_tail", rd, 8'h99);
        io_read(6'd5, rd); check("t5_stat1", rd, 8'h11);
        io_write(6'd4, 8'h00);
        io_write(6'd4, 8'h00);
        io_read(6'd5, rd); check("t5_empty_pop", rd, 8'h00);
        io_read(6'd4, rd); check("t5_empty_data", rd, 8'h00);
        bus.address = IO_BASE + 16'd4; bus.wren = 1'b1; ps2_data = 8'h77; ps2_hit = 1'b1;
        cyc(); bus.wren = 1'b0; ps2_hit = 1'b0;
        io_read(6'd5, rd); check("t5_empty_pp", rd, 8'h11);
        io_read(6'd4, rd); check("t5_empty_pp_d", rd, 8'h77);
        for (int i = 0; i < 15; i++) push(8'h60 + 8'(i));
        io_read(6'd5, rd); check("t5_refull", rd, 8'hF3);
        bus.address = IO_BASE + 16'd5; bus.data_o = 8'h04; bus.wren = 1'b1;
        ps2_data = 8'h88; ps2_hit = 1'b1;
        cyc(); bus.wren = 1'b0; ps2_hit = 1'b0;
        io_read(6'd5, rd); check("t5_set_wins", rd, 8'hF7);

        // 6: reset with bytes queued
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        io_write(6'd0, 8'h83); io_write(6'd1, 8'h07);
        io_read(6'd5, rd); check("t6_pre_stat", rd, 8'h51);
        check("t6_pre_bank", bank, 8'h83);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("t6_bank", bank, 8'h00);
        check("t6_vmode", videomode, 8'h00);
        check("t6_cursor", {cursor_x, cursor_y}, 16'h0000);
        check("t6_irq", kbd_irq, 1'b0);
        io_read(6'd4, rd); check("t6_data", rd, 8'h00);
        io_read(6'd5, rd); check("t6_stat", rd, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
